// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: line sync, ps2_clk glitch filter, 11-bit frame deframer and E0/F0 prefix stripper.
// Optional saturating frame-error counter on err_cnt when PS2_ERR_CNT_EN is defined.
module ps2_scancode_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000,
    parameter int TO_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       flag,
`ifdef PS2_ERR_CNT_EN
    output logic [7:0] err_cnt,
`endif
    output logic       ext
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          clk_f_q, clk_f_d, fall_q, fall_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic          byte_ok_q, byte_ok_d, frame_err_q, frame_err_d;
    logic [7:0]    scancode_q, scancode_d;
    logic          ext_q, ext_d, flag_q, flag_d, brk_q, brk_d, ext_p_q, ext_p_d;

    // Two-flop synchronisers; preset to the idle-high line level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filter: the synced clock must disagree with the filtered level FILTER_LEN samples in a row
    always_comb begin
        clk_f_d    = clk_f_q;
        filt_cnt_d = filt_cnt_q;
        fall_d     = 1'b0;
        if (clk_s2_q == clk_f_q) begin
            filt_cnt_d = {FW{1'b0}};
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            clk_f_d    = clk_s2_q;
            filt_cnt_d = {FW{1'b0}};
            fall_d     = ~clk_s2_q;
        end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
        end
    end

    // Frame FSM next state; timeout only runs while a frame is in progress
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        to_cnt_d    = to_cnt_q;
        byte_ok_d   = 1'b0;
        frame_err_d = 1'b0;
        if (fall_q) begin
            to_cnt_d = {TO_W{1'b0}};
            case (state_q)
                IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        byte_ok_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            to_cnt_d = {TO_W{1'b0}};
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            to_cnt_d    = {TO_W{1'b0}};
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Prefix decoder: F0 marks a release, E0 marks an extended code; errors drop both marks
    always_comb begin
        scancode_d = scancode_q;
        ext_d      = ext_q;
        flag_d     = 1'b0;
        brk_d      = brk_q;
        ext_p_d    = ext_p_q;
        if (frame_err_q) begin
            brk_d   = 1'b0;
            ext_p_d = 1'b0;
        end else if (byte_ok_q) begin
            if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                ext_p_d = 1'b1;
            end else begin
                if (!brk_q) begin
                    scancode_d = shift_q;
                    ext_d      = ext_p_q;
                    flag_d     = 1'b1;
                end else begin
                    flag_d = 1'b0;
                end
                brk_d   = 1'b0;
                ext_p_d = 1'b0;
            end
        end else begin
            flag_d = 1'b0;
        end
    end

    // State registers for filter, FSM and decoder
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_f_q     <= 1'b1;
            filt_cnt_q  <= {FW{1'b0}};
            fall_q      <= 1'b0;
            state_q     <= IDLE;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= {TO_W{1'b0}};
            byte_ok_q   <= 1'b0;
            frame_err_q <= 1'b0;
            scancode_q  <= 8'h00;
            ext_q       <= 1'b0;
            flag_q      <= 1'b0;
            brk_q       <= 1'b0;
            ext_p_q     <= 1'b0;
        end else begin
            clk_f_q     <= clk_f_d;
            filt_cnt_q  <= filt_cnt_d;
            fall_q      <= fall_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            byte_ok_q   <= byte_ok_d;
            frame_err_q <= frame_err_d;
            scancode_q  <= scancode_d;
            ext_q       <= ext_d;
            flag_q      <= flag_d;
            brk_q       <= brk_d;
            ext_p_q     <= ext_p_d;
        end
    end

`ifdef PS2_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Saturating error counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= 8'h00;
        end else if (frame_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end else begin
            err_cnt_q <= err_cnt_q;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign scancode = scancode_q;
    assign ext      = ext_q;
    assign flag     = flag_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: a PS/2 device model drives frames, a scoreboard checks each flag strobe.
module tb_ps2_scancode_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 300;
    localparam int TO_W       = 9;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scancode;
    logic       flag;
    logic       ext;
`ifdef PS2_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int flag_cnt = 0;
    logic flag_prev = 1'b0;
    logic [8:0] sb[$];

    ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .scancode(scancode),
        .flag(flag),
`ifdef PS2_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .ext(ext)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every flag strobe must match the oldest expected {ext, code}
    always @(negedge clk) begin
        if (reset && flag) begin
            logic [8:0] e;
            flag_cnt++;
            check("flag_single", {31'd0, flag_prev}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_flag", {23'd0, ext, scancode}, 32'h1FF);
            end else begin
                e = sb.pop_front();
                check("scancode", {24'd0, scancode}, {24'd0, e[7:0]});
                check("ext", {31'd0, ext}, {31'd0, e[8]});
            end
        end
        flag_prev = flag;
    end

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_scancode", {24'd0, scancode}, 32'h00);
        check("rst_flag", {31'd0, flag}, 32'd0);
        check("rst_ext", {31'd0, ext}, 32'd0);
`ifdef PS2_ERR_CNT_EN
        check("rst_err", {24'd0, err_cnt}, 32'd0);
`endif
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Plain make code
        sb.push_back({1'b0, 8'h72});
        send_frame(8'h72, 1'b0);
        check("t1_drained", sb.size(), 32'd0);

        // Extended make, then extended break must not strobe
        sb.push_back({1'b1, 8'h75});
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("t2_drained", sb.size(), 32'd0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("t2_brk_code", {24'd0, scancode}, 32'h75);
        check("t2_brk_ext", {31'd0, ext}, 32'd1);

        // Parity error
        send_frame(8'h6B, 1'b1);
        check("t3_hold", {24'd0, scancode}, 32'h75);
`ifdef PS2_ERR_CNT_EN
        check("t3_err", {24'd0, err_cnt}, 32'd1);
`endif

        // Partial frame abandoned by timeout
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 50) @(negedge clk);
`ifdef PS2_ERR_CNT_EN
        check("t4_err", {24'd0, err_cnt}, 32'd2);
`endif
        sb.push_back({1'b0, 8'h74});
        send_frame(8'h74, 1'b0);
        check("t4_drained", sb.size(), 32'd0);

        // Short clock glitch with data low: a real fall here would corrupt the next frame
        @(negedge clk);
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
        ps2_data = 1'b1;
        repeat (30) @(negedge clk);
        check("t5_noflag", flag_cnt, 32'd3);
        sb.push_back({1'b0, 8'h6B});
        send_frame(8'h6B, 1'b0);
        check("t5_drained", sb.size(), 32'd0);
`ifdef PS2_ERR_CNT_EN
        repeat (TIMEOUT + 50) @(negedge clk);
        check("t5_err", {24'd0, err_cnt}, 32'd2);
`endif

        // Reset in the middle of a 0x72 frame
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_scancode", {24'd0, scancode}, 32'h00);
        check("t6_ext", {31'd0, ext}, 32'd0);
        check("t6_flag", {31'd0, flag}, 32'd0);
`ifdef PS2_ERR_CNT_EN
        check("t6_err", {24'd0, err_cnt}, 32'd0);
`endif
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        sb.push_back({1'b0, 8'h6B});
        send_frame(8'h6B, 1'b0);
        check("t6_drained", sb.size(), 32'd0);
        check("t6_code", {24'd0, scancode}, 32'h6B);
        check("total_flags", flag_cnt, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
